// File: rtl/pcileech_tlps128_rr_arbiter.sv
// Two-input packet-atomic arbiter for 128-bit TLP streams. An input is locked from its
// first beat to tlast; selection is round-robin, or strict priority to in0 with a starvation cap.
module pcileech_tlps128_rr_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk_pcie,
    input  logic         rst,
    // requester 0
    input  logic [127:0] tlps_in0_tdata,
    input  logic [3:0]   tlps_in0_tkeepdw,
    input  logic         tlps_in0_tlast,
    input  logic [8:0]   tlps_in0_tuser,
    input  logic         tlps_in0_has_data,
    input  logic         tlps_in0_tvalid,
    output logic         tlps_in0_tready,
    // requester 1
    input  logic [127:0] tlps_in1_tdata,
    input  logic [3:0]   tlps_in1_tkeepdw,
    input  logic         tlps_in1_tlast,
    input  logic [8:0]   tlps_in1_tuser,
    input  logic         tlps_in1_has_data,
    input  logic         tlps_in1_tvalid,
    output logic         tlps_in1_tready,
    // shared downstream
    output logic [127:0] tlps_out_tdata,
    output logic [3:0]   tlps_out_tkeepdw,
    output logic         tlps_out_tlast,
    output logic [8:0]   tlps_out_tuser,
    output logic         tlps_out_has_data,
    output logic         tlps_out_tvalid,
    input  logic         tlps_out_tready,
    // status
    output logic [1:0]   grant,
    output logic [31:0]  pkt_cnt0,
    output logic [31:0]  pkt_cnt1,
    output logic [1:0]   dbg_state
);

    // Handshake: a beat transfers on a rising edge where tvalid & tready are both high;
    // a source holds its beat stable until it transfers. tready never depends on the
    // source's own tvalid, so there is no combinational loop back to the requester.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state, state_n;
    logic        last_grant;
    logic [7:0]  starve_cnt;
    logic [31:0] pkt_cnt0_q, pkt_cnt1_q;
    logic        pick0, pick1, done0, done1;

    always_comb begin
        state_n = state;
        pick0   = 1'b0;
        pick1   = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        case (state)
            IDLE: begin
                if (tlps_in0_tvalid && !tlps_in1_tvalid) begin
                    pick0 = 1'b1;
                end else if (tlps_in1_tvalid && !tlps_in0_tvalid) begin
                    pick1 = 1'b1;
                end else if (tlps_in0_tvalid && tlps_in1_tvalid) begin
                    if (PRIO_MODE == 0) begin
                        pick0 = last_grant;
                        pick1 = !last_grant;
                    end else begin
                        pick1 = (starve_cnt >= LIMIT);
                        pick0 = !(starve_cnt >= LIMIT);
                    end
                end
                if (pick0) begin
                    state_n = LOCK0;
                end else if (pick1) begin
                    state_n = LOCK1;
                end
            end
            LOCK0: begin
                done0 = tlps_in0_tvalid && tlps_out_tready && tlps_in0_tlast;
                if (done0) state_n = IDLE;
            end
            LOCK1: begin
                done1 = tlps_in1_tvalid && tlps_out_tready && tlps_in1_tlast;
                if (done1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            starve_cnt <= 8'd0;
            pkt_cnt0_q <= 32'd0;
            pkt_cnt1_q <= 32'd0;
        end else begin
            state <= state_n;
            if (pick0 && tlps_in1_tvalid && starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end else if (pick1) begin
                starve_cnt <= 8'd0;
            end
            if (done0) begin
                last_grant <= 1'b0;
                pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
            end
            if (done1) begin
                last_grant <= 1'b1;
                pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
            end
        end
    end

    // Pure combinational steering; outputs are forced quiet while reset is held.
    always_comb begin
        tlps_out_tdata    = '0;
        tlps_out_tkeepdw  = '0;
        tlps_out_tlast    = 1'b0;
        tlps_out_tuser    = '0;
        tlps_out_has_data = 1'b0;
        tlps_out_tvalid   = 1'b0;
        tlps_in0_tready   = 1'b0;
        tlps_in1_tready   = 1'b0;
        grant             = 2'b00;
        if (!rst) begin
            case (state)
                LOCK0: begin
                    tlps_out_tdata    = tlps_in0_tdata;
                    tlps_out_tkeepdw  = tlps_in0_tkeepdw;
                    tlps_out_tlast    = tlps_in0_tlast;
                    tlps_out_tuser    = tlps_in0_tuser;
                    tlps_out_has_data = tlps_in0_has_data;
                    tlps_out_tvalid   = tlps_in0_tvalid;
                    tlps_in0_tready   = tlps_out_tready;
                    grant             = 2'b01;
                end
                LOCK1: begin
                    tlps_out_tdata    = tlps_in1_tdata;
                    tlps_out_tkeepdw  = tlps_in1_tkeepdw;
                    tlps_out_tlast    = tlps_in1_tlast;
                    tlps_out_tuser    = tlps_in1_tuser;
                    tlps_out_has_data = tlps_in1_has_data;
                    tlps_out_tvalid   = tlps_in1_tvalid;
                    tlps_in1_tready   = tlps_out_tready;
                    grant             = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_pcileech_tlps128_rr_arbiter.sv
// Directed bench for the TLP arbiter: one round-robin instance and one priority instance
// (STARVE_LIMIT=3), each driven from its own stimulus signals on a shared clock.
module tb_pcileech_tlps128_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    // round-robin instance stimulus / observation
    logic         rst;
    logic [127:0] i0_data, i1_data;
    logic [3:0]   i0_keep, i1_keep;
    logic         i0_last, i1_last, i0_valid, i1_valid;
    logic [8:0]   i0_user, i1_user;
    logic         i0_hd, i1_hd;
    logic         i0_ready, i1_ready, o_ready;
    logic [127:0] o_data;
    logic [3:0]   o_keep;
    logic         o_last, o_hd, o_valid;
    logic [8:0]   o_user;
    logic [1:0]   r_grant, r_state;
    logic [31:0]  r_cnt0, r_cnt1;

    // priority instance stimulus / observation
    logic         p_rst, p_v0, p_v1, p_r0, p_r1, p_last, p_hd, p_valid;
    logic [127:0] p_data;
    logic [3:0]   p_keep;
    logic [8:0]   p_user;
    logic [1:0]   p_grant, p_state;
    logic [31:0]  p_cnt0, p_cnt1;

    localparam logic [127:0] P0_DATA = {4{32'h0000_00AA}};
    localparam logic [127:0] P1_DATA = {4{32'h0000_0055}};

    pcileech_tlps128_rr_arbiter u_rr (
        .clk_pcie(clk), .rst(rst),
        .tlps_in0_tdata(i0_data), .tlps_in0_tkeepdw(i0_keep), .tlps_in0_tlast(i0_last),
        .tlps_in0_tuser(i0_user), .tlps_in0_has_data(i0_hd), .tlps_in0_tvalid(i0_valid),
        .tlps_in0_tready(i0_ready),
        .tlps_in1_tdata(i1_data), .tlps_in1_tkeepdw(i1_keep), .tlps_in1_tlast(i1_last),
        .tlps_in1_tuser(i1_user), .tlps_in1_has_data(i1_hd), .tlps_in1_tvalid(i1_valid),
        .tlps_in1_tready(i1_ready),
        .tlps_out_tdata(o_data), .tlps_out_tkeepdw(o_keep), .tlps_out_tlast(o_last),
        .tlps_out_tuser(o_user), .tlps_out_has_data(o_hd), .tlps_out_tvalid(o_valid),
        .tlps_out_tready(o_ready),
        .grant(r_grant), .pkt_cnt0(r_cnt0), .pkt_cnt1(r_cnt1), .dbg_state(r_state)
    );

    pcileech_tlps128_rr_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(3)) u_pr (
        .clk_pcie(clk), .rst(p_rst),
        .tlps_in0_tdata(P0_DATA), .tlps_in0_tkeepdw(4'hF), .tlps_in0_tlast(1'b1),
        .tlps_in0_tuser(9'h0), .tlps_in0_has_data(1'b1), .tlps_in0_tvalid(p_v0),
        .tlps_in0_tready(p_r0),
        .tlps_in1_tdata(P1_DATA), .tlps_in1_tkeepdw(4'hF), .tlps_in1_tlast(1'b1),
        .tlps_in1_tuser(9'h0), .tlps_in1_has_data(1'b1), .tlps_in1_tvalid(p_v1),
        .tlps_in1_tready(p_r1),
        .tlps_out_tdata(p_data), .tlps_out_tkeepdw(p_keep), .tlps_out_tlast(p_last),
        .tlps_out_tuser(p_user), .tlps_out_has_data(p_hd), .tlps_out_tvalid(p_valid),
        .tlps_out_tready(1'b1),
        .grant(p_grant), .pkt_cnt0(p_cnt0), .pkt_cnt1(p_cnt1), .dbg_state(p_state)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 units after it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive0(input logic v, input logic [127:0] d, input logic l);
        i0_valid = v; i0_data = d; i0_last = l;
    endtask

    task automatic drive1(input logic v, input logic [127:0] d, input logic l);
        i1_valid = v; i1_data = d; i1_last = l;
    endtask

    initial begin
        rst = 1'b1; p_rst = 1'b1; p_v0 = 1'b0; p_v1 = 1'b0; o_ready = 1'b1;
        drive0(1'b1, 128'h0, 1'b0); drive1(1'b1, 128'h0, 1'b0);
        i0_keep = 4'hF; i1_keep = 4'h3; i0_user = 9'h1A5; i1_user = 9'h05A;
        i0_hd = 1'b1; i1_hd = 1'b0;

        // reset state, with both requesters asserting valid
        repeat (3) next_cycle();
        settle();
        check("rst_grant", r_grant, 2'b00);
        check("rst_tvalid", o_valid, 1'b0);
        check("rst_tready0", i0_ready, 1'b0);
        check("rst_tready1", i1_ready, 1'b0);
        check("rst_cnt0", r_cnt0, 32'd0);
        check("rst_cnt1", r_cnt1, 32'd0);
        check("rst_state", r_state, 2'd0);

        // single 3-beat packet from in0
        next_cycle();
        rst = 1'b0;
        drive1(1'b0, 128'h0, 1'b0);
        drive0(1'b1, 128'hA0, 1'b0);
        exp_q.push_back(128'hA0); exp_q.push_back(128'hA1); exp_q.push_back(128'hA2);
        settle();
        check("p3_idle_grant", r_grant, 2'b00);
        check("p3_idle_tready0", i0_ready, 1'b0);
        check("p3_idle_tvalid", o_valid, 1'b0);
        for (int b = 0; b < 3; b++) begin
            next_cycle();
            drive0(1'b1, 128'hA0 + 128'(b), (b == 2));
            settle();
            check("p3_grant", r_grant, 2'b01);
            check("p3_tvalid", o_valid, 1'b1);
            check("p3_tready0", i0_ready, 1'b1);
            check("p3_tready1", i1_ready, 1'b0);
            check("p3_data", o_data, exp_q.pop_front());
            check("p3_last", o_last, (b == 2));
        end
        check("p3_keep", o_keep, 4'hF);
        check("p3_user", o_user, 9'h1A5);
        check("p3_has_data", o_hd, 1'b1);
        next_cycle();
        drive0(1'b0, 128'h0, 1'b0);
        settle();
        check("p3_end_grant", r_grant, 2'b00);
        check("p3_end_cnt0", r_cnt0, 32'd1);

        // both inputs always offer 1-beat packets; in0 went last, so in1 wins first
        drive0(1'b1, P0_DATA, 1'b1);
        drive1(1'b1, P1_DATA, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            settle();
            if (i % 2 == 0) begin
                check("rr_bubble", r_grant, 2'b00);
            end else if ((i / 2) % 2 == 0) begin
                check("rr_grant1", r_grant, 2'b10);
                check("rr_data1", o_data, P1_DATA);
                check("rr_keep1", o_keep, 4'h3);
            end else begin
                check("rr_grant0", r_grant, 2'b01);
                check("rr_data0", o_data, P0_DATA);
                check("rr_keep0", o_keep, 4'hF);
            end
            next_cycle();
        end
        drive0(1'b0, 128'h0, 1'b0);
        drive1(1'b0, 128'h0, 1'b0);
        settle();
        check("rr_cnt0", r_cnt0, 32'd501);
        check("rr_cnt1", r_cnt1, 32'd500);

        // LOCK1 under 5 cycles of backpressure while in0 waits
        next_cycle();
        drive1(1'b1, 128'hB0, 1'b0);
        settle();
        check("bp_idle_grant", r_grant, 2'b00);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            drive0(1'b1, 128'hC0, 1'b1);
            o_ready = 1'b0;
            settle();
            check("bp_grant", r_grant, 2'b10);
            check("bp_data", o_data, 128'hB0);
            check("bp_tvalid", o_valid, 1'b1);
            check("bp_tready0", i0_ready, 1'b0);
            check("bp_tready1", i1_ready, 1'b0);
            check("bp_cnt1", r_cnt1, 32'd500);
        end
        next_cycle();
        o_ready = 1'b1;
        settle();
        check("bp_beat0", o_data, 128'hB0);
        check("bp_tready1_on", i1_ready, 1'b1);
        next_cycle();
        drive1(1'b1, 128'hB1, 1'b1);
        settle();
        check("bp_beat1", o_data, 128'hB1);
        check("bp_last", o_last, 1'b1);
        next_cycle();
        drive1(1'b0, 128'h0, 1'b0);
        settle();
        check("bp_end_grant", r_grant, 2'b00);
        check("bp_end_cnt1", r_cnt1, 32'd501);
        next_cycle();
        settle();
        check("bp_in0_grant", r_grant, 2'b01);
        check("bp_in0_data", o_data, 128'hC0);
        next_cycle();
        drive0(1'b0, 128'h0, 1'b0);
        settle();
        check("bp_in0_cnt0", r_cnt0, 32'd502);

        // reset on beat 2 of a 4-beat in0 packet
        drive0(1'b1, 128'hD0, 1'b0);
        next_cycle();
        settle();
        check("rp_beat1", o_data, 128'hD0);
        next_cycle();
        drive0(1'b1, 128'hD1, 1'b0);
        rst = 1'b1;
        settle();
        check("rp_rst_tvalid", o_valid, 1'b0);
        check("rp_rst_tready0", i0_ready, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive0(1'b0, 128'h0, 1'b0);
        drive1(1'b1, 128'hE0, 1'b1);
        settle();
        check("rp_grant", r_grant, 2'b00);
        check("rp_tvalid", o_valid, 1'b0);
        check("rp_cnt0", r_cnt0, 32'd0);
        next_cycle();
        settle();
        check("rp_new_grant", r_grant, 2'b10);
        check("rp_new_data", o_data, 128'hE0);
        next_cycle();
        drive1(1'b0, 128'h0, 1'b0);
        settle();
        check("rp_new_cnt1", r_cnt1, 32'd1);

        // pkt_cnt1 wrap from all-ones
        force u_rr.pkt_cnt1_q = 32'hFFFF_FFFF;
        #1;
        release u_rr.pkt_cnt1_q;
        check("wrap_preload", r_cnt1, 32'hFFFF_FFFF);
        next_cycle();
        drive1(1'b1, 128'hF0, 1'b1);
        next_cycle();
        settle();
        check("wrap_grant", r_grant, 2'b10);
        next_cycle();
        drive1(1'b0, 128'h0, 1'b0);
        settle();
        check("wrap_cnt1", r_cnt1, 32'd0);
        check("wrap_cnt0", r_cnt0, 32'd0);

        // priority mode, limit 3: in0,in0,in0,in1 repeating, bubble between packets
        next_cycle();
        p_rst = 1'b0;
        p_v0 = 1'b1;
        p_v1 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            settle();
            if (i % 2 == 0) begin
                check("pr_bubble", p_grant, 2'b00);
            end else if ((i / 2) % 4 == 3) begin
                check("pr_grant1", p_grant, 2'b10);
                check("pr_data1", p_data, P1_DATA);
            end else begin
                check("pr_grant0", p_grant, 2'b01);
                check("pr_data0", p_data, P0_DATA);
            end
            next_cycle();
        end
        p_v0 = 1'b0;
        p_v1 = 1'b0;
        settle();
        check("pr_cnt0", p_cnt0, 32'd12);
        check("pr_cnt1", p_cnt1, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcileech_tlps128_rr_arbiter.md
PCILEECH_TLPS128_RR_ARBITER -- requirements
Module: pcileech_tlps128_rr_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin, 1 = strict priority to input 0 with anti-starvation.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive in0 grants while in1 waits before in1 is forced; range 1..255.
REQ-003 SHALL have port clk_pcie  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tlps_in0  IfAXIS128.sink  --  requester 0 TLP stream.
REQ-006 SHALL have port tlps_in1  IfAXIS128.sink  --  requester 1 TLP stream.
REQ-007 SHALL have port tlps_out  IfAXIS128.source  --  shared downstream TLP stream, e.g. toward the jitter stage.
REQ-008 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-009 SHALL have ports pkt_cnt0, pkt_cnt1  output  32  packets forwarded per input.

Function
REQ-010 SHALL implement states IDLE, LOCK0, LOCK1; grant = 00 / 01 / 10 respectively.
REQ-011 In IDLE, tready to both inputs and tlps_out.tvalid SHALL be 0; the arbitration decision is registered, and the next state applies one cycle later.
REQ-012 IDLE with only inN.tvalid=1 SHALL transition to LOCKN.
REQ-013 IDLE with both valid, PRIO_MODE=0, SHALL grant the input opposite to register last_grant; last_grant resets to 1, so in0 wins the first tie.
REQ-014 IDLE with both valid, PRIO_MODE=1, SHALL grant in0 unless starve_cnt >= STARVE_LIMIT, in which case it grants in1.
REQ-015 starve_cnt (8-bit, saturating) SHALL increment when in0 is granted while in1.tvalid=1, SHALL clear when in1 is granted, and SHALL otherwise hold.
REQ-016 In LOCKN, tdata, tkeepdw, tlast, tuser, has_data and tvalid on tlps_out SHALL equal inN combinationally; inN.tready = tlps_out.tready; the non-granted tready = 0.
REQ-017 Packets SHALL be atomic: the state SHALL leave LOCKN only on a beat with inN.tvalid & tlps_out.tready & inN.tlast.
REQ-018 On that last beat the state SHALL go to IDLE, last_grant SHALL be set to N, and pkt_cntN SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-019 In LOCKN, inN.tvalid deasserting mid-packet SHALL hold LOCKN indefinitely, with no timeout and no switching.
REQ-020 Downstream backpressure (tready=0) SHALL hold the state and leave the counters unchanged.
REQ-021 Input signals SHALL be sampled only under valid handshake; tdata is don't-care when tvalid=0.
REQ-022 Throughput: one idle bubble cycle per packet; single-beat packets from alternating inputs SHALL sustain 1 packet per 2 cycles.
REQ-023 The block SHALL contain no data buffering; the output path is combinational from the granted input.

Reset
REQ-024 While rst=1: state = IDLE, grant = 00, both tready = 0, tlps_out.tvalid = 0, last_grant = 1, starve_cnt = 0, pkt_cnt0 = pkt_cnt1 = 0.
REQ-025 rst asserted mid-packet SHALL abandon the packet; the counter SHALL NOT increment; the first cycle after reset release is IDLE.

Verification
REQ-026 Case: only in0 sends a 3-beat packet with tready=1. Required: grant=01 one cycle after tvalid, 3 output beats, then grant=00 and pkt_cnt0=1.
REQ-027 Case: PRIO_MODE=0, both inputs continuously offer 1-beat packets. Required: grant order 01,10,01,10..., no beat from the non-granted input ever appears, counts equal after 2K cycles.
REQ-028 Case: PRIO_MODE=1, STARVE_LIMIT=3, both continuously valid. Required: grant sequence in0,in0,in0,in1 repeating.
REQ-029 Case: in LOCK1, tlps_out.tready=0 for 5 cycles mid-packet, with in0 valid throughout. Required: in1 data held stable on output, in0.tready=0, grant stays 10, packet completes intact.
REQ-030 Case: rst pulsed on beat 2 of a 4-beat in0 packet. Required: next cycle grant=00, tvalid=0, pkt_cnt0=0, and new arbitration proceeds normally.
REQ-031 Case: pkt_cnt1 preloaded to 0xFFFFFFFF by force, then one in1 packet is sent. Required: pkt_cnt1=0.
